mem_arbiter: RTL and testbench

Two-port arbiter that shares the single `memory_controller` between the expression fetch FSM (port 0) and the cons/heap allocator (port 1). It grants at most one memory access per cycle, round-robin on conflict, with an optional lock for multi-word sequences such as tag/car/cdr. It steers the combinational request of the granted port onto the memory pins. It tracks in-flight reads so each port gets its own `rvalid` strobe after the fixed read latency.

---
 rtl/mem_arbiter.sv | 119 +++++++++++
 tb/tb_mem_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module   : mem_arbiter
// Brief    : Two-port round-robin memory arbiter with lock and read tracking.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module mem_arbiter #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 16,
   parameter int RD_LATENCY = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  boot_done,
   input  logic                  p0_req,
   input  logic                  p0_we,
   input  logic                  p0_lock,
   input  logic [ADDR_WIDTH-1:0] p0_addr,
   input  logic [DATA_WIDTH-1:0] p0_wdata,
   input  logic                  p1_req,
   input  logic                  p1_we,
   input  logic                  p1_lock,
   input  logic [ADDR_WIDTH-1:0] p1_addr,
   input  logic [DATA_WIDTH-1:0] p1_wdata,
   output logic                  p0_gnt,
   output logic                  p1_gnt,
   output logic                  p0_rvalid,
   output logic                  p1_rvalid,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_read_enable,
   output logic                  mem_write_enable,
   output logic [DATA_WIDTH-1:0] mem_write_data,
   input  logic [DATA_WIDTH-1:0] mem_read_data,
   output logic                  busy
);

   logic                  locked_q, locked_d;
   logic                  owner_q, owner_d;
   logic                  last_grant_q, last_grant_d;
   logic [RD_LATENCY-1:0] pipe_vld_q, pipe_vld_d;
   logic [RD_LATENCY-1:0] pipe_port_q, pipe_port_d;

   logic                  elig0, elig1;
   logic                  accept, sel;
   logic                  sel_we, sel_lock, owner_lock;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [DATA_WIDTH-1:0] sel_wdata;

   always_comb begin
      elig0 = boot_done & p0_req & (~locked_q | ~owner_q);
      elig1 = boot_done & p1_req & (~locked_q |  owner_q);
      // On a tie the port that did not win last time takes the slot.
      p0_gnt = elig0 & (~elig1 | last_grant_q);
      p1_gnt = elig1 & ~p0_gnt;
      accept = p0_gnt | p1_gnt;
      sel    = p1_gnt;

      sel_we     = sel ? p1_we    : p0_we;
      sel_lock   = sel ? p1_lock  : p0_lock;
      sel_addr   = sel ? p1_addr  : p0_addr;
      sel_wdata  = sel ? p1_wdata : p0_wdata;
      owner_lock = owner_q ? p1_lock : p0_lock;

      mem_addr         = accept ? sel_addr : '0;
      mem_read_enable  = accept & ~sel_we;
      mem_write_enable = accept &  sel_we;
      mem_write_data   = (accept & sel_we) ? sel_wdata : '0;

      locked_d     = locked_q;
      owner_d      = owner_q;
      last_grant_d = last_grant_q;
      if (locked_q && !owner_lock) begin
         locked_d = 1'b0;
      end
      if (accept) begin
         last_grant_d = sel;
         if (sel_lock) begin
            locked_d = 1'b1;
            owner_d  = sel;
         end
      end

      pipe_vld_d     = '0;
      pipe_port_d    = '0;
      pipe_vld_d[0]  = accept & ~sel_we;
      pipe_port_d[0] = sel;
      for (int i = 1; i < RD_LATENCY; i++) begin
         pipe_vld_d[i]  = pipe_vld_q[i-1];
         pipe_port_d[i] = pipe_port_q[i-1];
      end

      p0_rvalid = pipe_vld_q[RD_LATENCY-1] & ~pipe_port_q[RD_LATENCY-1];
      p1_rvalid = pipe_vld_q[RD_LATENCY-1] &  pipe_port_q[RD_LATENCY-1];
      rdata     = mem_read_data;
      busy      = |pipe_vld_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         locked_q     <= 1'b0;
         owner_q      <= 1'b0;
         last_grant_q <= 1'b1;
         pipe_vld_q   <= '0;
         pipe_port_q  <= '0;
      end else begin
         locked_q     <= locked_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
         pipe_vld_q   <= pipe_vld_d;
         pipe_port_q  <= pipe_port_d;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Scoreboard bench for mem_arbiter with a reference arbitration model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mem_arbiter;

   localparam int AW  = 16;
   localparam int DW  = 16;
   localparam int LAT = 2;

   logic          clk = 1'b0;
   logic          rst, boot_done;
   logic          p0_req, p0_we, p0_lock, p1_req, p1_we, p1_lock;
   logic [AW-1:0] p0_addr, p1_addr;
   logic [DW-1:0] p0_wdata, p1_wdata;
   logic          p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, busy;
   logic [DW-1:0] rdata, mem_write_data, mem_read_data;
   logic [AW-1:0] mem_addr;
   logic          mem_read_enable, mem_write_enable;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(LAT)) dut (
      .clk(clk), .rst(rst), .boot_done(boot_done),
      .p0_req(p0_req), .p0_we(p0_we), .p0_lock(p0_lock), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
      .p1_req(p1_req), .p1_we(p1_we), .p1_lock(p1_lock), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
      .p0_gnt(p0_gnt), .p1_gnt(p1_gnt), .p0_rvalid(p0_rvalid), .p1_rvalid(p1_rvalid),
      .rdata(rdata), .mem_addr(mem_addr), .mem_read_enable(mem_read_enable),
      .mem_write_enable(mem_write_enable), .mem_write_data(mem_write_data),
      .mem_read_data(mem_read_data), .busy(busy)
   );

   function automatic logic [DW-1:0] init_word(int a);
      return DW'(16'hA500 ^ (a * 16'h0101));
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   // Memory controller stand-in: fixed-latency read return.
   logic [DW-1:0] env_mem [256];
   logic [DW-1:0] dl [LAT];
   bit            env_init = 1'b0;
   always @(posedge clk) begin
      if (!env_init) begin
         for (int i = 0; i < 256; i++) env_mem[i] <= init_word(i);
         for (int i = 0; i < LAT; i++) dl[i] <= 16'hDEAD;
         env_init <= 1'b1;
      end else begin
         if (mem_write_enable) env_mem[mem_addr[7:0]] <= mem_write_data;
         for (int i = LAT-1; i > 0; i--) dl[i] <= dl[i-1];
         dl[0] <= mem_read_enable ? env_mem[mem_addr[7:0]] : 16'hDEAD;
      end
   end
   assign mem_read_data = dl[LAT-1];

   // Reference model and scoreboard.
   typedef struct {
      int            port;
      logic [DW-1:0] data;
      int            acc;
      int            due;
   } rd_t;
   rd_t           sb [$];
   logic [DW-1:0] ref_mem [int];
   bit            m_locked = 1'b0;
   int            m_owner  = 0;
   int            m_last   = 1;

   always @(negedge clk) begin
      bit e0, e1, acc, we, lk, olk;
      int g, a;
      logic [DW-1:0] wd;
      if (rst) begin
         sb.delete();
         m_locked = 1'b0;
         m_owner  = 0;
         m_last   = 1;
      end else begin
         e0  = boot_done && p0_req && (!m_locked || m_owner == 0);
         e1  = boot_done && p1_req && (!m_locked || m_owner == 1);
         acc = e0 || e1;
         g   = (e0 && e1) ? 1 - m_last : (e1 ? 1 : 0);
         we  = (g == 1) ? p1_we : p0_we;
         lk  = (g == 1) ? p1_lock : p0_lock;
         a   = (g == 1) ? int'(p1_addr) : int'(p0_addr);
         wd  = (g == 1) ? p1_wdata : p0_wdata;
         chk("p0_gnt", 32'(p0_gnt), 32'(acc && g == 0));
         chk("p1_gnt", 32'(p1_gnt), 32'(acc && g == 1));
         chk("mem_addr", 32'(mem_addr), acc ? 32'(a) : 32'd0);
         chk("mem_re", 32'(mem_read_enable), 32'(acc && !we));
         chk("mem_we", 32'(mem_write_enable), 32'(acc && we));
         chk("mem_wdata", 32'(mem_write_data), (acc && we) ? 32'(wd) : 32'd0);
         olk = (m_owner == 1) ? p1_lock : p0_lock;
         if (m_locked && !olk) m_locked = 1'b0;
         if (acc) begin
            m_last = g;
            if (lk) begin
               m_locked = 1'b1;
               m_owner  = g;
            end
            if (we) ref_mem[a & 255] = wd;
            else sb.push_back('{port: g,
                                data: ref_mem.exists(a & 255) ? ref_mem[a & 255] : init_word(a & 255),
                                acc: cyc, due: cyc + LAT});
         end
      end
   end

   always @(negedge clk) begin
      bit b_exp, due_now;
      if (!rst) begin
         b_exp = 1'b0;
         foreach (sb[i]) if (sb[i].acc < cyc && sb[i].due >= cyc) b_exp = 1'b1;
         chk("busy", 32'(busy), 32'(b_exp));
         due_now = sb.size() > 0 && sb[0].due == cyc;
         chk("p0_rvalid", 32'(p0_rvalid), 32'(due_now && sb[0].port == 0));
         chk("p1_rvalid", 32'(p1_rvalid), 32'(due_now && sb[0].port == 1));
         if (due_now) begin
            chk("rdata", 32'(rdata), 32'(sb[0].data));
            void'(sb.pop_front());
         end
      end
   end

   task automatic step(int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic idle();
      p0_req = 0; p0_we = 0; p0_lock = 0; p0_addr = '0; p0_wdata = '0;
      p1_req = 0; p1_we = 0; p1_lock = 0; p1_addr = '0; p1_wdata = '0;
   endtask

   initial begin
      bit a0, a1;
      rst = 1'b1; boot_done = 1'b0; idle();
      step(3);
      rst = 1'b0;
      step(1);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_rvalid", 32'({p0_rvalid, p1_rvalid}), 32'd0);

      // Boot gating
      p0_req = 1; p0_addr = 16'h0010;
      step(2);
      boot_done = 1'b1;
      step(1);
      idle(); step(4);

      // Round-robin
      p0_req = 1; p0_addr = 16'h0020; p1_req = 1; p1_addr = 16'h0030;
      step(8);
      idle(); step(4);

      // Lock with idle gap
      p1_req = 1; p1_addr = 16'h0031;
      p0_req = 1; p0_addr = 16'h0040; p0_lock = 1;
      step(1);
      p0_addr = 16'h0041;
      step(1);
      p0_req = 0;
      step(1);
      p0_req = 1; p0_addr = 16'h0042; p0_lock = 0;
      step(1);
      p0_req = 0;
      step(2);
      idle(); step(4);

      // Write then read back
      p1_req = 1; p1_we = 1; p1_addr = 16'h0050; p1_wdata = 16'hBEEF;
      step(1);
      idle(); p0_req = 1; p0_addr = 16'h0050;
      step(1);
      idle(); step(4);

      // Reset mid-read, then tie
      p0_req = 1; p0_addr = 16'h0060;
      step(1);
      idle(); rst = 1'b1;
      step(1);
      rst = 1'b0; p0_req = 1; p0_addr = 16'h0070; p1_req = 1; p1_addr = 16'h0071;
      step(1);
      idle(); step(4);

      // Randomized traffic
      for (int k = 0; k < 3000; k++) begin
         @(negedge clk);
         a0 = p0_req && p0_gnt;
         a1 = p1_req && p1_gnt;
         step(1);
         boot_done = ($urandom_range(0, 15) != 0);
         if (!p0_req || a0) begin
            p0_req   = ($urandom_range(0, 2) != 0);
            p0_we    = p0_req && ($urandom_range(0, 2) == 0);
            p0_lock  = p0_req && ($urandom_range(0, 3) == 0);
            p0_addr  = AW'($urandom_range(0, 15));
            p0_wdata = DW'($urandom);
         end
         if (!p1_req || a1) begin
            p1_req   = ($urandom_range(0, 2) != 0);
            p1_we    = p1_req && ($urandom_range(0, 2) == 0);
            p1_lock  = p1_req && ($urandom_range(0, 3) == 0);
            p1_addr  = AW'($urandom_range(0, 15));
            p1_wdata = DW'($urandom);
         end
      end
      idle(); boot_done = 1'b1;
      step(LAT + 4);
      chk("drain", 32'(sb.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
